// File: rtl/interrupt_controller_if.sv
// CPU data-bus view of the interrupt controller register window.
// The CPU drives address/data/strobes; the controller returns read data and the address-hit flag.
interface interrupt_controller_if;
    logic [31:0] address;
    logic [31:0] data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rdata;
    logic        IntCtrlAddress;

    modport master (
        output address, data, MemRead, MemWrite,
        input  rdata, IntCtrlAddress
    );

    modport slave (
        input  address, data, MemRead, MemWrite,
        output rdata, IntCtrlAddress
    );
endinterface

// File: rtl/interrupt_controller.sv
// Four-source fixed-priority interrupt controller with STATUS/MASK/ACK/CAUSE registers
// and an IDLE/ASSERT/SERVICE claim handshake toward the CPU.
module interrupt_controller #(
    parameter logic [31:0] BASE = 32'hffff0070
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [3:0]             irq,
    interrupt_controller_if.slave  bus,
    output logic                   CPUInterrupt,
    output logic [3:0]             src_ack
);
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] ASSERT  = 2'b01;
    localparam logic [1:0] SERVICE = 2'b10;

    logic [3:0] pending, pending_n;
    logic [3:0] mask, mask_n;
    logic [3:0] eligible;
    logic [3:0] wdata;
    logic [3:0] ack_clr;
    logic [1:0] state, state_n;
    logic [1:0] cur_id, winner;
    logic       sel_status, sel_mask, sel_ack, sel_cause;
    logic       wr_mask, wr_ack, rd_cause;

    assign sel_status = (bus.address == BASE);
    assign sel_mask   = (bus.address == BASE + 32'd4);
    assign sel_ack    = (bus.address == BASE + 32'd8);
    assign sel_cause  = (bus.address == BASE + 32'd12);
    assign bus.IntCtrlAddress = sel_status | sel_mask | sel_ack | sel_cause;

    assign wdata    = bus.data[3:0];
    assign wr_mask  = bus.MemWrite & sel_mask;
    assign wr_ack   = bus.MemWrite & sel_ack;
    assign rd_cause = bus.MemRead & sel_cause;

    // A live request wins over an ACK of the same bit.
    assign ack_clr   = wr_ack ? (wdata & ~irq) : 4'b0000;
    assign pending_n = (pending | irq) & ~ack_clr;
    assign mask_n    = wr_mask ? wdata : mask;
    assign eligible  = pending & mask;

    always_comb begin
        winner = 2'd0;
        if (eligible[0])      winner = 2'd0;
        else if (eligible[1]) winner = 2'd1;
        else if (eligible[2]) winner = 2'd2;
        else if (eligible[3]) winner = 2'd3;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (eligible != 4'b0000) state_n = ASSERT;
            // Withdrawal looks at next-cycle mask/pending so a same-cycle ACK or MASK write counts.
            ASSERT:  if (!mask_n[cur_id] || !pending_n[cur_id]) state_n = IDLE;
                     else if (rd_cause)                          state_n = SERVICE;
            SERVICE: if (wr_ack && wdata[cur_id]) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pending <= '0;
            mask    <= '0;
            state   <= IDLE;
            cur_id  <= '0;
            src_ack <= '0;
        end else begin
            pending <= pending_n;
            mask    <= mask_n;
            state   <= state_n;
            if (state == IDLE && eligible != 4'b0000)
                cur_id <= winner;
            src_ack <= wr_ack ? wdata : 4'b0000;
        end
    end

    assign CPUInterrupt = (state == ASSERT);

    always_comb begin
        bus.rdata = '0;
        if (bus.MemRead) begin
            if (sel_status)     bus.rdata = {28'b0, pending};
            else if (sel_mask)  bus.rdata = {28'b0, mask};
            else if (sel_cause) bus.rdata = {state != IDLE, 29'b0, cur_id};
        end
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: register access, priority, claim/ACK flow,
// withdrawal, re-assertion and synchronous reset.
module tb_interrupt_controller;
    localparam logic [31:0] BASE   = 32'hffff0070;
    localparam logic [31:0] STATUS = BASE;
    localparam logic [31:0] MASKA  = BASE + 32'd4;
    localparam logic [31:0] ACKA   = BASE + 32'd8;
    localparam logic [31:0] CAUSE  = BASE + 32'd12;

    logic       clock;
    logic       reset;
    logic [3:0] irq;
    logic       CPUInterrupt;
    logic [3:0] src_ack;
    int         checks;
    int         errors;

    interrupt_controller_if bus ();

    interrupt_controller #(.BASE(BASE)) dut (
        .clock        (clock),
        .reset        (reset),
        .irq          (irq),
        .bus          (bus),
        .CPUInterrupt (CPUInterrupt),
        .src_ack      (src_ack)
    );

    initial clock = 1'b0;
    always #50 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Combinational read with no clock edge, so no claim side effect.
    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.address = a;
        bus.MemRead = 1'b1;
        #1;
        check(tag, bus.rdata, exp);
        bus.MemRead = 1'b0;
        bus.address = '0;
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.address  = a;
        bus.data     = d;
        bus.MemWrite = 1'b1;
        cycle();
        bus.MemWrite = 1'b0;
        bus.address  = '0;
        bus.data     = '0;
    endtask

    task automatic claim(input string tag, input logic [31:0] exp);
        bus.address = CAUSE;
        bus.MemRead = 1'b1;
        #1;
        check(tag, bus.rdata, exp);
        cycle();
        bus.MemRead = 1'b0;
        bus.address = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        irq = '0;
        bus.address = '0;
        bus.data = '0;
        bus.MemRead = 1'b0;
        bus.MemWrite = 1'b0;
        cycle();
        cycle();
        check("rst_cpuint", 32'(CPUInterrupt), 32'd0);
        check("rst_srcack", 32'(src_ack), 32'd0);
        peek("rst_cause", CAUSE, 32'h0);
        reset = 1'b1;

        // Address decode and read gating
        bus.address = CAUSE; #1;
        check("dec_cause", 32'(bus.IntCtrlAddress), 32'd1);
        bus.address = BASE + 32'd16; #1;
        check("dec_above", 32'(bus.IntCtrlAddress), 32'd0);
        bus.address = BASE - 32'd4; #1;
        check("dec_below", 32'(bus.IntCtrlAddress), 32'd0);
        bus.address = '0;

        // Basic timer interrupt: pend, assert, claim
        bus_write(MASKA, 32'h1);
        peek("mask_rd", MASKA, 32'h1);
        irq = 4'b0001;
        cycle();
        check("lat_pend_noint", 32'(CPUInterrupt), 32'd0);
        peek("lat_status", STATUS, 32'h1);
        bus.address = STATUS; #1;
        check("rdata_noread", bus.rdata, 32'h0);
        bus.address = '0;
        cycle();
        check("lat_assert", 32'(CPUInterrupt), 32'd1);
        claim("claim0_cause", 32'h80000000);
        check("svc0_cpuint", 32'(CPUInterrupt), 32'd0);
        peek("svc0_cause", CAUSE, 32'h80000000);

        // ACK in SERVICE with source dropped
        irq = 4'b0000;
        cycle();
        bus_write(ACKA, 32'h1);
        check("ack0_srcack", 32'(src_ack), 32'h1);
        peek("ack0_status", STATUS, 32'h0);
        peek("ack0_cause", CAUSE, 32'h0);
        check("ack0_cpuint", 32'(CPUInterrupt), 32'd0);
        cycle();
        check("ack0_pulse_end", 32'(src_ack), 32'h0);

        // Writes to STATUS/CAUSE are ignored
        bus_write(STATUS, 32'hF);
        bus_write(CAUSE, 32'hF);
        peek("ro_status", STATUS, 32'h0);
        peek("ro_mask", MASKA, 32'h1);

        // Priority: bits 1 and 3 together
        bus_write(MASKA, 32'hF);
        irq = 4'b1010;
        cycle();
        cycle();
        check("prio_assert", 32'(CPUInterrupt), 32'd1);
        peek("prio_cause1", CAUSE, 32'h80000001);
        claim("prio_claim1", 32'h80000001);
        irq = 4'b1000;
        bus_write(ACKA, 32'h2);
        check("prio_srcack", 32'(src_ack), 32'h2);
        check("prio_idle", 32'(CPUInterrupt), 32'd0);
        peek("prio_status", STATUS, 32'h8);
        cycle();
        check("prio_assert3", 32'(CPUInterrupt), 32'd1);
        peek("prio_cause3", CAUSE, 32'h80000003);
        irq = 4'b0000;
        claim("prio_claim3", 32'h80000003);
        bus_write(ACKA, 32'h8);
        peek("prio_clean", STATUS, 32'h0);

        // Masked pending, enable, then withdraw by mask write
        bus_write(MASKA, 32'h0);
        irq = 4'b0100;
        cycle();
        irq = 4'b0000;
        cycle();
        check("mask_noint", 32'(CPUInterrupt), 32'd0);
        peek("mask_status", STATUS, 32'h4);
        bus_write(MASKA, 32'h4);
        check("mask_wr_noint", 32'(CPUInterrupt), 32'd0);
        cycle();
        check("mask_assert", 32'(CPUInterrupt), 32'd1);
        peek("mask_cause", CAUSE, 32'h80000002);
        bus_write(MASKA, 32'h0);
        check("withdraw_int", 32'(CPUInterrupt), 32'd0);
        peek("withdraw_cause", CAUSE, 32'h00000002);
        bus_write(ACKA, 32'h4);
        check("withdraw_srcack", 32'(src_ack), 32'h4);
        peek("withdraw_status", STATUS, 32'h0);

        // ACK while source still high re-enters ASSERT
        bus_write(MASKA, 32'h1);
        irq = 4'b0001;
        cycle();
        cycle();
        claim("reassert_claim", 32'h80000000);
        bus_write(ACKA, 32'h1);
        check("reassert_srcack", 32'(src_ack), 32'h1);
        check("reassert_idle", 32'(CPUInterrupt), 32'd0);
        peek("reassert_status", STATUS, 32'h1);
        cycle();
        check("reassert_int", 32'(CPUInterrupt), 32'd1);
        claim("reassert_claim2", 32'h80000000);
        check("svc_before_rst", 32'(CPUInterrupt), 32'd0);

        // Reset mid-SERVICE overrides a simultaneous write
        reset = 1'b0;
        irq = 4'b0000;
        bus_write(ACKA, 32'hF);
        check("rst_svc_srcack", 32'(src_ack), 32'h0);
        check("rst_svc_int", 32'(CPUInterrupt), 32'd0);
        peek("rst_svc_status", STATUS, 32'h0);
        peek("rst_svc_cause", CAUSE, 32'h0);
        bus_write(MASKA, 32'hF);
        peek("rst_mask_wr", MASKA, 32'h0);
        reset = 1'b1;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
